// File: rtl/sfp_event_tx_sched.sv
// sfp_event_tx_sched: per-cycle slot scheduler for the outgoing SFP event stream
// Ports: clk_i, reset_i (async, active-low); dbus_i -> txdata_o[15:8] one cycle later;
//        req_i/code_i/ack_o round-robin requester handshake; sec_load_i/sec_value_i/
//        sec_busy_o/sec_overrun_o seconds serialiser; txdata_o/txcharisk_o event word.
// Build option: define SFP_TX_HEARTBEAT_EN to add the periodic 0x7A heartbeat source.
module sfp_event_tx_sched #(
   parameter int N_REQ     = 4,
   parameter int HB_PERIOD = 4096
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [7:0]         dbus_i,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [8*N_REQ-1:0] code_i,
   output logic [N_REQ-1:0]   ack_o,
   input  logic               sec_load_i,
   input  logic [31:0]        sec_value_i,
   output logic               sec_busy_o,
   output logic               sec_overrun_o,
   output logic [15:0]        txdata_o,
   output logic [1:0]         txcharisk_o
);
   localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, RST} seq_t;
   seq_t             state, state_n;
   logic [31:0]      sr, sr_n;
   logic [4:0]       cnt, cnt_n;
   logic [PW-1:0]    ptr, ptr_n;
   logic [N_REQ-1:0] elig, grant;
   logic [7:0]       code;
   logic             parity, k_char, seq_slot, overrun, hb_pend;
   if (N_REQ < 1 || N_REQ > 8 || HB_PERIOD < 64) begin : g_bad_param
      $error("sfp_event_tx_sched: parameter out of range");
   end
`ifdef SFP_TX_HEARTBEAT_EN
   localparam int HW = $clog2(HB_PERIOD);
   logic [HW-1:0] hb_cnt;
   logic          hb_wrap;
   assign hb_wrap = hb_cnt == HW'(HB_PERIOD - 1);
   // Pending is a single flag: a wrap while already pending is absorbed; any non-seconds slot consumes it.
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         hb_cnt  <= '0;
         hb_pend <= 1'b0;
      end else begin
         hb_cnt  <= hb_wrap ? '0 : hb_cnt + 1'b1;
         hb_pend <= hb_wrap | (hb_pend & seq_slot);
      end
`else
   assign hb_pend = 1'b0;
`endif
   always_comb begin
      state_n  = state;
      sr_n     = sr;
      cnt_n    = cnt;
      ptr_n    = ptr;
      grant    = '0;
      overrun  = 1'b0;
      seq_slot = 1'b1;
      k_char   = 1'b0;
      code     = 8'h00;
      // A requester acked this cycle is still holding req; keep it out of this decision.
      elig     = req_i & ~ack_o;
      if (state == SHIFT) begin
         code    = sr[31] ? 8'h71 : 8'h70;
         sr_n    = {sr[30:0], 1'b0};
         cnt_n   = cnt - 1'b1;
         state_n = cnt == 5'd0 ? RST : SHIFT;
         overrun = sec_load_i;
      end else if (state == RST) begin
         code    = 8'h7D;
         state_n = IDLE;
         overrun = sec_load_i;
      end else if (sec_load_i) begin
         // The load slot already carries the MSB, so SHIFT covers the remaining 31 bits.
         code    = sec_value_i[31] ? 8'h71 : 8'h70;
         sr_n    = {sec_value_i[30:0], 1'b0};
         cnt_n   = 5'd30;
         state_n = SHIFT;
      end else begin
         seq_slot = 1'b0;
         if (hb_pend) begin
            code = 8'h7A;
         end else if (|elig) begin
            // Descending scan so the nearest eligible index after the pointer wins.
            for (int i = N_REQ; i >= 1; i--)
               if (elig[PW'((int'(ptr) + i) % N_REQ)]) ptr_n = PW'((int'(ptr) + i) % N_REQ);
            grant[ptr_n] = 1'b1;
            code         = code_i[8*ptr_n +: 8];
         end else begin
            code   = parity ? 8'hBC : 8'h00;
            k_char = parity;
         end
      end
   end
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         state         <= IDLE;
         sr            <= '0;
         cnt           <= '0;
         ptr           <= PW'(N_REQ - 1);
         parity        <= 1'b0;
         ack_o         <= '0;
         sec_busy_o    <= 1'b0;
         sec_overrun_o <= 1'b0;
         txdata_o      <= '0;
         txcharisk_o   <= '0;
      end else begin
         state         <= state_n;
         sr            <= sr_n;
         cnt           <= cnt_n;
         ptr           <= ptr_n;
         parity        <= ~parity;
         ack_o         <= grant;
         sec_busy_o    <= seq_slot;
         sec_overrun_o <= overrun;
         txdata_o      <= {dbus_i, code};
         txcharisk_o   <= {1'b0, k_char};
      end
endmodule

// File: tb/tb_sfp_event_tx_sched.sv
// tb_sfp_event_tx_sched: randomized self-checking bench for sfp_event_tx_sched against a queue-based model
module tb_sfp_event_tx_sched;
   localparam int N   = 4;
   localparam int HBP = 64;
`ifdef SFP_TX_HEARTBEAT_EN
   localparam bit HB_ON = 1'b1;
`else
   localparam bit HB_ON = 1'b0;
`endif
   logic           clk_i = 1'b0, reset_i = 1'b0;
   logic [7:0]     dbus_i = '0;
   logic [N-1:0]   req_i = '0, ack_o;
   logic [8*N-1:0] code_i = '0;
   logic           sec_load_i = 1'b0, sec_busy_o, sec_overrun_o;
   logic [31:0]    sec_value_i = '0;
   logic [15:0]    txdata_o;
   logic [1:0]     txcharisk_o;
   logic [23:0]    obs, e_out;
   logic [N-1:0]   ack_prev, drop_en, m_last_ack;
   byte unsigned   seq_q[$];
   bit             m_par, m_hb_pend;
   int             m_ptr, m_hb_cnt;
   int             checks = 0, passes = 0;

   sfp_event_tx_sched #(.N_REQ(N), .HB_PERIOD(HBP)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .dbus_i(dbus_i), .req_i(req_i), .code_i(code_i),
      .ack_o(ack_o), .sec_load_i(sec_load_i), .sec_value_i(sec_value_i),
      .sec_busy_o(sec_busy_o), .sec_overrun_o(sec_overrun_o),
      .txdata_o(txdata_o), .txcharisk_o(txcharisk_o));

   always #5 clk_i = ~clk_i;
   assign obs = {txdata_o, txcharisk_o, ack_o, sec_busy_o, sec_overrun_o};

   task automatic model_reset();
      seq_q.delete();
      m_par      = 1'b0;
      m_ptr      = N - 1;
      m_hb_cnt   = 0;
      m_hb_pend  = 1'b0;
      m_last_ack = '0;
      ack_prev   = '0;
   endtask

   // Predicts the word that appears after the coming edge from the inputs driven now.
   task automatic model_step();
      byte unsigned code;
      bit           k, busy, ovr;
      logic [N-1:0] g;
      int           w, j;
      code = 8'h00; k = 1'b0; busy = 1'b0; ovr = 1'b0; g = '0; w = -1;
      if (sec_load_i) begin
         if (seq_q.size() != 0) ovr = 1'b1;
         else begin
            for (int b = 31; b >= 0; b--) seq_q.push_back(sec_value_i[b] ? 8'h71 : 8'h70);
            seq_q.push_back(8'h7D);
         end
      end
      if (seq_q.size() != 0) begin
         code = seq_q.pop_front();
         busy = 1'b1;
      end else if (m_hb_pend) begin
         code      = 8'h7A;
         m_hb_pend = 1'b0;
      end else begin
         for (int i = 1; i <= N; i++) begin
            j = (m_ptr + i) % N;
            if (w < 0 && req_i[j] && !m_last_ack[j]) w = j;
         end
         if (w >= 0) begin
            g[w]  = 1'b1;
            code  = code_i[8*w +: 8];
            m_ptr = w;
         end else begin
            code = m_par ? 8'hBC : 8'h00;
            k    = m_par;
         end
      end
      m_par = ~m_par;
      if (HB_ON) begin
         if (m_hb_cnt == HBP - 1) begin
            m_hb_cnt  = 0;
            m_hb_pend = 1'b1;
         end else m_hb_cnt++;
      end
      m_last_ack = g;
      e_out = {dbus_i, code, 1'b0, k, g, busy, ovr};
   endtask

   // Requesters marked in drop_en release req on the edge that samples their ack.
   task automatic advance();
      req_i    = req_i & ~(ack_prev & drop_en);
      ack_prev = ack_o;
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      dbus_i  = 8'hFF;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (obs !== 24'h0) $display("FAIL reset_state got %h exp %h", obs, 24'h0); else passes++;
      @(negedge clk_i);
      reset_i = 1'b1;
      model_reset();
   endtask

   task automatic test_idle();
      drop_en = '1;
      for (int c = 0; c < 8; c++) begin
         dbus_i = (c == 0) ? 8'hA5 : 8'($urandom);
         advance();
         checks++;
         if (obs !== e_out) $display("FAIL idle c%0d got %h exp %h", c, obs, e_out); else passes++;
         if (c == 0) begin
            checks++;
            if (txdata_o[15:8] !== 8'hA5) $display("FAIL dbus_lat got %h exp a5", txdata_o[15:8]); else passes++;
         end
      end
   endtask

   task automatic test_rr_drop();
      logic [15:0] enc;
      int          n;
      enc = '0; n = 0;
      drop_en = '1;
      code_i  = {8'h40, 8'h30, 8'h20, 8'h10};
      req_i   = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         dbus_i = 8'($urandom);
         advance();
         checks++;
         if (obs !== e_out) $display("FAIL rr_drop c%0d got %h exp %h", c, obs, e_out); else passes++;
         for (int k = 0; k < N; k++) if (ack_o[k]) begin
            enc = {enc[11:0], 4'(k)};
            n++;
         end
      end
      checks++;
      if (n != 4 || enc !== 16'h0123) $display("FAIL rr_order got %0d grants %h exp 4 grants 0123", n, enc); else passes++;
   endtask

   task automatic test_rr_hold();
      int last, bad;
      last = -1; bad = 0;
      drop_en = '0;
      req_i   = 4'b0011;
      for (int c = 0; c < 10; c++) begin
         dbus_i = 8'($urandom);
         advance();
         checks++;
         if (obs !== e_out) $display("FAIL rr_hold c%0d got %h exp %h", c, obs, e_out); else passes++;
         for (int k = 0; k < N; k++) if (ack_o[k]) begin
            if (k == last) bad++;
            last = k;
         end
      end
      checks++;
      if (bad != 0) $display("FAIL rr_alternate got %0d repeats exp 0", bad); else passes++;
      req_i   = '0;
      drop_en = '1;
      repeat (2) advance();
   endtask

   task automatic test_seconds();
      byte unsigned s[$];
      int           acks;
      acks = 0;
      drop_en     = '1;
      code_i      = {8'h44, 8'h33, 8'h22, 8'h11};
      sec_value_i = 32'hA000_0001;
      sec_load_i  = 1'b1;
      req_i       = 4'b0110;
      for (int c = 0; c < 40; c++) begin
         dbus_i = 8'($urandom);
         advance();
         sec_load_i = 1'b0;
         checks++;
         if (obs !== e_out) $display("FAIL seconds c%0d got %h exp %h", c, obs, e_out); else passes++;
         if (sec_busy_o) s.push_back(txdata_o[7:0]);
         acks += $countones(ack_o);
      end
      checks++;
      if (s.size() != 33 || s[0] != 8'h71 || s[1] != 8'h70 || s[2] != 8'h71 || s[3] != 8'h70 ||
          s[30] != 8'h70 || s[31] != 8'h71 || s[32] != 8'h7D || acks != 2)
         $display("FAIL seconds_shape got busy %0d acks %0d exp busy 33 acks 2", s.size(), acks);
      else passes++;
   endtask

   task automatic test_overrun();
      int busy, ovr;
      busy = 0; ovr = 0;
      drop_en     = '1;
      sec_value_i = $urandom;
      sec_load_i  = 1'b1;
      for (int c = 0; c < 40; c++) begin
         dbus_i = 8'($urandom);
         advance();
         sec_load_i = (c == 9);
         if (c == 9) sec_value_i = ~sec_value_i;
         checks++;
         if (obs !== e_out) $display("FAIL overrun c%0d got %h exp %h", c, obs, e_out); else passes++;
         busy += sec_busy_o;
         ovr  += sec_overrun_o;
      end
      checks++;
      if (busy != 33 || ovr != 1) $display("FAIL overrun_count got busy %0d ovr %0d exp 33 1", busy, ovr); else passes++;
   endtask

   task automatic test_heartbeat();
      byte unsigned s[$];
      int           load_at, hb, after;
      hb = 0; after = -1;
      drop_en     = '1;
      req_i       = '0;
      sec_value_i = $urandom;
      // Start the sequence so a counter wrap lands in its middle.
      load_at = HB_ON ? (40 - m_hb_cnt + HBP) % HBP : 5;
      for (int c = 0; c < 200; c++) begin
         dbus_i     = 8'($urandom);
         sec_load_i = (c == load_at);
         advance();
         checks++;
         if (obs !== e_out) $display("FAIL heartbeat c%0d got %h exp %h", c, obs, e_out); else passes++;
         s.push_back(txdata_o[7:0]);
         if (txdata_o[7:0] == 8'h7A) hb++;
      end
      sec_load_i = 1'b0;
      for (int i = 0; i + 1 < s.size(); i++) if (s[i] == 8'h7D && after < 0) after = s[i+1];
      checks++;
      if (HB_ON ? (after != 8'h7A || hb < 3 || hb > 4) : (after == 8'h7A || hb != 0))
         $display("FAIL hb_pattern got after7d %h beats %0d exp hb_en %0d", after, hb, HB_ON);
      else passes++;
   endtask

   task automatic test_random();
      drop_en = '1;
      for (int c = 0; c < 1500; c++) begin
         dbus_i = 8'($urandom);
         for (int k = 0; k < N; k++) begin
            if (!req_i[k] && !ack_prev[k] && $urandom_range(3) == 0) begin
               code_i[8*k +: 8] = (k == 3 && $urandom_range(1) == 1) ? 8'hBC : 8'($urandom);
               req_i[k] = 1'b1;
            end else if (req_i[k] && !ack_o[k] && !ack_prev[k] && $urandom_range(31) == 0) req_i[k] = 1'b0;
         end
         sec_load_i  = $urandom_range(59) == 0;
         sec_value_i = $urandom;
         advance();
         checks++;
         if (obs !== e_out) $display("FAIL random c%0d got %h exp %h", c, obs, e_out); else passes++;
      end
      sec_load_i = 1'b0;
      req_i      = '0;
   endtask

   task automatic test_reset_mid();
      drop_en     = '1;
      sec_value_i = $urandom;
      sec_load_i  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         dbus_i = 8'($urandom);
         advance();
         sec_load_i = 1'b0;
         checks++;
         if (obs !== e_out) $display("FAIL mid_pre c%0d got %h exp %h", c, obs, e_out); else passes++;
      end
      #2 reset_i = 1'b0;
      #1;
      checks++;
      if (obs !== 24'h0) $display("FAIL mid_reset got %h exp %h", obs, 24'h0); else passes++;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b1;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         dbus_i = 8'($urandom);
         advance();
         checks++;
         if (obs !== e_out) $display("FAIL mid_post c%0d got %h exp %h", c, obs, e_out); else passes++;
      end
   endtask

   initial begin
      drop_en = '1;
      model_reset();
      test_reset();
      test_idle();
      test_rr_drop();
      test_rr_hold();
      test_seconds();
      test_overrun();
      test_heartbeat();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
